logo_motion_ctrl: RTL
=====================

# logo_motion_ctrl

Frame-rate animation controller producing the horizontal offset `delt` consumed by the logo painters. It detects each frame start from the VGA vertical sync and sweeps `delt` back and forth between 0 and a configurable maximum, with a configurable step, frame divider and end-of-travel dwell. It sits directly upstream of the logo painter and is clocked in the pixel-clock domain.

## Interface
- MAX_DELT, 100: upper travel limit of `delt`. Constraint: MAX_DELT + STEP ≤ 2047.
- STEP, 2: pixels moved per motion update, range 1..63.
- FRAME_DIV, 1: frames per motion update, range 1..255.
- DWELL, 30: frames held at each end before reversing, range 0..255.
- VS_ACTIVE_LOW, 1: polarity of `vsync`. 1 means the sync pulse is low.

- clk  in  1  pixel clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- enable  in  1  run animation; low freezes `delt`.
- vsync  in  1  VGA vertical sync, asynchronous to `clk`.
- delt  out  11  registered logo offset to the painter.
- dir  out  1  registered; 1 = moving or holding toward MAX_DELT, 0 = toward 0.
- frame_tick  out  1  registered one-cycle pulse per detected frame start.

## Operation
- **Sync path:** `vsync` passes through a 2-flop synchronizer, then a third flop for edge detection. The frame start is the synchronized sync pulse's leading edge (falling edge when VS_ACTIVE_LOW=1).
- **Motion counter:** `frame_cnt` (8-bit) increments on each `frame_tick` while the state is RIGHT or LEFT. A motion update occurs on a tick when `frame_cnt == FRAME_DIV-1`, and the counter then clears.
- **Dwell counter:** `dwell_cnt` (8-bit) increments on each tick while the state is HOLD_R or HOLD_L.
- **States:** IDLE, RIGHT, HOLD_R, LEFT, HOLD_L.
- **IDLE:**
  - `delt` and `dir` are held.
  - When `enable` = 1, go to RIGHT if `dir` = 1, otherwise LEFT.
  - Both counters clear.
- **RIGHT (update):**
  - If `delt + STEP ≥ MAX_DELT`: `delt` ← MAX_DELT and go to HOLD_R.
  - Otherwise `delt` ← `delt + STEP`.
  - Sums are computed in 12 bits, so there is no wrap.
- **HOLD_R (tick):**
  - When `dwell_cnt ≥ DWELL`: `dir` ← 0, go to LEFT, and clear `dwell_cnt`.
  - With DWELL = 0, the state is left on the first tick after entry.
- **LEFT (update):**
  - If `delt ≤ STEP`: `delt` ← 0 and go to HOLD_L.
  - Otherwise `delt` ← `delt - STEP`.
  - `delt` never underflows.
- **HOLD_L:** mirror of HOLD_R. On exit, `dir` ← 1 and go to RIGHT.
- **enable low:** `enable` = 0 in any state forces IDLE on the next edge and has priority over a coincident update. `delt` keeps its value. No reset or recentre occurs.
- **Out-of-range `delt`:** never produced. `delt` is always within 0..MAX_DELT.

## Timing
- **Reset values:** `delt` = 0, `dir` = 1, `frame_tick` = 0, state = IDLE, all counters 0. Synchronizer flops reset to the inactive sync level.
- **`frame_tick` latency:** goes high on the 3rd rising edge after `vsync` reaches its active level with setup met, and stays high for exactly 1 cycle.
- **`delt` latency:** changes on the edge after `frame_tick` is high, i.e. 1 cycle later. `delt` is stable for the whole visible frame.
- **Pulse width:** sync pulses shorter than 2 clk may be missed. Real VGA pulses are ≥ 2 lines, so this is acceptable.
- **Tick rate:** at most one update per frame regardless of sync glitches. After a tick, the edge detector requires the synchronized sync to return inactive before it can tick again.
- **Reset mid-frame or mid-hold:** immediate return to reset values. The first tick after release is counted only once `enable` is high.
- **`enable` mid-frame:** a tick arriving in the same cycle `enable` rises is ignored. This follows because the IDLE→run transition takes one edge.

## Test plan
- **Reset:** assert `rst` = 0 mid-sweep (`delt` = 40) → `delt` = 0, `dir` = 1 and `frame_tick` = 0 asynchronously; all outputs hold after release with `enable` = 0.
- **Sweep up (defaults):** `enable` = 1, 60 vsync pulses → after frame 50, `delt` = 100; `dir` = 1 during the 30-frame hold; `dir` = 0 and `delt` = 98 on the first update after the hold.
- **Clamp:** STEP = 3, MAX_DELT = 10, DWELL = 0 → `delt` sequence 0, 3, 6, 9, 10, 10, 7, 4, 1, 0, 0, 3; never 12 or negative.
- **Divider:** FRAME_DIV = 4 → `delt` changes only every 4th `frame_tick`; `frame_tick` is one cycle per vsync, 3 clk after the vsync falling edge.
- **Freeze:** drop `enable` at `delt` = 56 for 10 frames → `delt` stays 56; on re-enable it resumes in the same direction (58).
- **Glitch:** 1-clk vsync spike plus a normal pulse in one frame → at most one `frame_tick` and one update.

Source files
------------

// File: rtl/logo_motion_ctrl.sv
// Purpose: frame-rate ping-pong animation of the logo offset delt, paced by VGA vsync.
// Latency: frame_tick 3 clk after vsync goes active; delt/dir update 1 clk after frame_tick.
// Backpressure: none; the painter samples delt freely, enable low freezes motion in place.
module logo_motion_ctrl #(
  parameter int MAX_DELT      = 100,
  parameter int STEP          = 2,
  parameter int FRAME_DIV     = 1,
  parameter int DWELL         = 30,
  parameter int VS_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        vsync,
  output logic [10:0] delt,
  output logic        dir,
  output logic        frame_tick
);

  // Level vsync rests at between pulses; synchronizer flops reset here.
  localparam logic        VS_IDLE  = 1'(VS_ACTIVE_LOW != 0);
  localparam logic [11:0] MAX12    = 12'(MAX_DELT);
  localparam logic [11:0] STEP12   = 12'(STEP);
  localparam logic [10:0] MAX11    = 11'(MAX_DELT);
  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [7:0]  DWELL8   = 8'(DWELL);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RIGHT  = 3'd1,
    S_HOLD_R = 3'd2,
    S_LEFT   = 3'd3,
    S_HOLD_L = 3'd4
  } state_t;

  logic        vs_s1_q, vs_s1_d;
  logic        vs_s2_q, vs_s2_d;
  logic        vs_s3_q, vs_s3_d;
  logic        tick_q, tick_d;
  state_t      state_q, state_d;
  logic [10:0] delt_q, delt_d;
  logic        dir_q, dir_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  dwell_cnt_q, dwell_cnt_d;

  logic        act1, act2, act3;
  logic [11:0] sum_up;
  logic        upd;

  // Synchronizer chain plus edge-detect stage, and the frame-start qualifier.
  // s1 only confirms that the pulse is still active one sample later, so a
  // 1-clk spike never ticks; s3 must be inactive, so one pulse gives one tick.
  always_comb begin
    vs_s1_d = vsync;
    vs_s2_d = vs_s1_q;
    vs_s3_d = vs_s2_q;
    act1    = vs_s1_q ^ VS_IDLE;
    act2    = vs_s2_q ^ VS_IDLE;
    act3    = vs_s3_q ^ VS_IDLE;
    tick_d  = act2 & act1 & ~act3;
  end

  // Motion FSM: next state, offset, direction and frame/dwell counters.
  always_comb begin
    state_d     = state_q;
    delt_d      = delt_q;
    dir_d       = dir_q;
    frame_cnt_d = frame_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    sum_up      = {1'b0, delt_q} + STEP12;
    upd         = tick_q && (frame_cnt_q == DIV_LAST);

    if (!enable) begin
      // Freeze wins over any coincident update; offset and direction are kept.
      state_d     = S_IDLE;
      frame_cnt_d = 8'd0;
      dwell_cnt_d = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          frame_cnt_d = 8'd0;
          dwell_cnt_d = 8'd0;
          state_d     = dir_q ? S_RIGHT : S_LEFT;
        end
        S_RIGHT: begin
          if (tick_q) begin
            if (upd) begin
              frame_cnt_d = 8'd0;
              if (sum_up >= MAX12) begin
                delt_d  = MAX11;
                state_d = S_HOLD_R;
              end else begin
                delt_d = sum_up[10:0];
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
        S_HOLD_R: begin
          if (tick_q) begin
            if (dwell_cnt_q >= DWELL8) begin
              dir_d       = 1'b0;
              state_d     = S_LEFT;
              dwell_cnt_d = 8'd0;
            end else begin
              dwell_cnt_d = dwell_cnt_q + 8'd1;
            end
          end
        end
        S_LEFT: begin
          if (tick_q) begin
            if (upd) begin
              frame_cnt_d = 8'd0;
              if ({1'b0, delt_q} <= STEP12) begin
                delt_d  = 11'd0;
                state_d = S_HOLD_L;
              end else begin
                delt_d = delt_q - STEP11;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
        S_HOLD_L: begin
          if (tick_q) begin
            if (dwell_cnt_q >= DWELL8) begin
              dir_d       = 1'b1;
              state_d     = S_RIGHT;
              dwell_cnt_d = 8'd0;
            end else begin
              dwell_cnt_d = dwell_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_d     = S_IDLE;
          frame_cnt_d = 8'd0;
          dwell_cnt_d = 8'd0;
        end
      endcase
    end
  end

  // State registers; synchronizer flops reset to the inactive sync level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_s1_q     <= VS_IDLE;
      vs_s2_q     <= VS_IDLE;
      vs_s3_q     <= VS_IDLE;
      tick_q      <= 1'b0;
      state_q     <= S_IDLE;
      delt_q      <= 11'd0;
      dir_q       <= 1'b1;
      frame_cnt_q <= 8'd0;
      dwell_cnt_q <= 8'd0;
    end else begin
      vs_s1_q     <= vs_s1_d;
      vs_s2_q     <= vs_s2_d;
      vs_s3_q     <= vs_s3_d;
      tick_q      <= tick_d;
      state_q     <= state_d;
      delt_q      <= delt_d;
      dir_q       <= dir_d;
      frame_cnt_q <= frame_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign delt       = delt_q;
  assign dir        = dir_q;
  assign frame_tick = tick_q;

endmodule
